gauss_window_ctrl: RTL

- Sequencer for the 3x3 Gaussian datapath (line buffers + window registers + combinational 9-tap computing block).
- Accepts a raster pixel stream, drives window-shift and zero-pad controls, and emits a per-output `corner_type` code so the datapath masks out-of-image taps.
- Flushes the tail of the frame with padded shifts, so exactly IMG_W*IMG_H results come out per frame.

---
 rtl/gauss_pkg.sv | 36 +++
 rtl/gauss_window_ctrl_pos_counter.sv | 35 +++
 rtl/gauss_window_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - corner codes, controller states and corner classification for the 3x3 Gaussian sequencer
package gauss_pkg;

  localparam logic [3:0] CT_IDLE   = 4'd0;
  localparam logic [3:0] CT_START  = 4'd1;
  localparam logic [3:0] CT_RSTART = 4'd2;
  localparam logic [3:0] CT_LEFT   = 4'd3;
  localparam logic [3:0] CT_RIGHT  = 4'd4;
  localparam logic [3:0] CT_LEND   = 4'd5;
  localparam logic [3:0] CT_REND   = 4'd6;
  localparam logic [3:0] CT_FULL   = 4'd8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FILL  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Top/bottom middle columns stay CT_FULL: cleared line buffers and pad shifts supply the zeros.
  function automatic logic [3:0] corner_code(input int r, input int c, input int w, input int h);
    logic [3:0] code;
    code = CT_FULL;
    if (c == 0) begin
      if (r == 0)          code = CT_START;
      else if (r == h - 1) code = CT_LEND;
      else                 code = CT_LEFT;
    end else if (c == w - 1) begin
      if (r == 0)          code = CT_RSTART;
      else if (r == h - 1) code = CT_REND;
      else                 code = CT_RIGHT;
    end
    return code;
  endfunction

endpackage

// File: rtl/gauss_window_ctrl_pos_counter.sv
// rtl/gauss_window_ctrl_pos_counter.sv - raster row/col counter with clear, enable, col-wrap and last flags
module gauss_pos_counter #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             col_wrap,
  output logic             last
);

  assign col_wrap = (col == COL_W'(IMG_W - 1));
  assign last     = col_wrap && (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gauss_window_ctrl.sv
// rtl/gauss_window_ctrl.sv - sequencer driving window shifts, zero padding and corner codes for the 3x3 Gaussian datapath
module gauss_window_ctrl
  import gauss_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             lb_clear,
  output logic             shift_en,
  output logic             pad_zero,
  output logic             win_valid,
  output logic [3:0]       corner_type,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(IMG_W * IMG_H + 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] FLUSH_N   = CNT_W'(IMG_W + 1);

  state_t           state;
  logic [CNT_W-1:0] icnt;
  logic             accept;
  logic             flush_shift;
  logic             emit;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;
  logic             pos_wrap;
  logic             pos_last;

  always_comb begin
    in_ready    = ((state == ST_FILL) || (state == ST_RUN)) && out_ready;
    accept      = in_ready && in_valid;
    flush_shift = (state == ST_FLUSH) && out_ready && (icnt < FLUSH_N);
    shift_en    = accept || flush_shift;
    pad_zero    = flush_shift;
    lb_clear    = (state == ST_IDLE) && start && !rst;
    emit        = ((state == ST_RUN) && accept) || flush_shift;
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
  end

  gauss_pos_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clr     (lb_clear),
    .en      (emit),
    .row     (pos_row),
    .col     (pos_col),
    .col_wrap(pos_wrap),
    .last    (pos_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      icnt        <= '0;
      win_valid   <= 1'b0;
      corner_type <= CT_IDLE;
      out_row     <= '0;
      out_col     <= '0;
      out_last    <= 1'b0;
    end else begin
      win_valid   <= emit;
      corner_type <= emit ? corner_code(int'(pos_row), int'(pos_col), IMG_W, IMG_H) : CT_IDLE;
      out_last    <= emit && pos_last;
      if (emit) begin
        out_row <= pos_row;
        out_col <= pos_col;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FILL;
            icnt  <= '0;
          end
        end
        ST_FILL: begin
          if (accept) begin
            icnt <= icnt + 1'b1;
            if (icnt == FILL_LAST) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (icnt == PIX_LAST) begin
              state <= ST_FLUSH;
              icnt  <= '0;
            end else begin
              icnt <= icnt + 1'b1;
            end
          end
        end
        // icnt now counts padded shifts; leave once the final result has been presented
        ST_FLUSH: begin
          if (flush_shift) icnt <= icnt + 1'b1;
          if (win_valid && out_last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
